// File: rtl/rr_decode_arbiter_pkg.sv
// rr_decode_arbiter_pkg
//   Shared definitions for the round-robin decode arbiter:
//   - arb_state_t : FSM state encoding (IDLE / GRANT)
//   - clog2_min1  : ceiling log2, never less than 1, used to size
//                   index and counter fields
package rr_decode_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2 that never returns 0. A 1-bit field is still needed
    // when the value range collapses to a single value.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_idx_onehot.sv
// rr_idx_onehot
//   Combinational binary-to-one-hot converter with enable.
//   Ports:
//     en  : in  1   when 0 the output is all zero
//     idx : in  IW  binary index (values >= N give zero output)
//     y   : out N   one-hot of idx when en=1
module rr_idx_onehot #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          en,
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            y[i] = en && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//   Round-robin arbiter that hands one shared decoded resource to one of
//   N requesters at a time. gnt_idx feeds a decoder address and gnt_valid
//   its enable.
//
//   Handshake: req[i] is a level request. While gnt_valid=1 the owner is
//   gnt_idx (and gnt = onehot(gnt_idx)). The grant ends on the edge where
//   done=1, the owner drops req, or the grant has lasted MAX_HOLD cycles;
//   the last case alone raises a one-cycle timeout pulse. After a release
//   there is always one idle cycle before the next grant.
//
//   Ports:
//     clk         : in  1   rising-edge clock
//     rst         : in  1   synchronous active-high reset
//     req         : in  N   per-requester request
//     done        : in  1   owner finished, release this edge
//     gnt         : out N   registered one-hot grant
//     gnt_idx     : out IW  binary index of owner (holds after release)
//     gnt_valid   : out 1   grant active
//     timeout     : out 1   pulse on forced release
//     o_dbg_state : out     current FSM state
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    localparam int IW      = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          timeout,
    output arb_state_t    o_dbg_state
);

    localparam int HW = clog2_min1(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gnt_idx;
    logic          r_gnt_valid;
    logic [N-1:0]  r_gnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_timeout;

    arb_state_t    w_nxt_state;
    logic [IW-1:0] w_nxt_ptr;
    logic [IW-1:0] w_nxt_idx;
    logic          w_nxt_valid;
    logic [N-1:0]  w_nxt_gnt;
    logic [HW-1:0] w_nxt_hold;
    logic          w_nxt_timeout;

    logic          w_found;
    logic [IW-1:0] w_sel;
    logic          w_owner_req;
    logic          w_hit_max;
    logic          w_release;

    // Rotating find-first: scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(r_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_sel   = IW'(k);
            end
        end
    end

    assign w_owner_req = req[r_gnt_idx];
    assign w_hit_max   = (r_hold_cnt == HOLD_LAST);
    assign w_release   = done || !w_owner_req || w_hit_max;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_ptr     = r_ptr;
        w_nxt_idx     = r_gnt_idx;
        w_nxt_valid   = r_gnt_valid;
        w_nxt_hold    = r_hold_cnt;
        w_nxt_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_idx   = w_sel;
                    w_nxt_valid = 1'b1;
                    w_nxt_hold  = '0;
                end
            end
            ST_GRANT: begin
                w_nxt_hold = r_hold_cnt + 1'b1;
                if (w_release) begin
                    w_nxt_state   = ST_IDLE;
                    w_nxt_valid   = 1'b0;
                    w_nxt_hold    = '0;
                    w_nxt_ptr     = (r_gnt_idx == IW'(N - 1)) ? '0 : r_gnt_idx + 1'b1;
                    // Timeout only when the hold limit is the sole reason.
                    w_nxt_timeout = w_hit_max && !done && w_owner_req;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    // gnt is registered from the decoded next index so it lines up with
    // gnt_idx/gnt_valid on the same edge.
    rr_idx_onehot #(
        .N  (N),
        .IW (IW)
    ) u_onehot (
        .en  (w_nxt_valid),
        .idx (w_nxt_idx),
        .y   (w_nxt_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= '0;
            r_hold_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_ptr       <= w_nxt_ptr;
            r_gnt_idx   <= w_nxt_idx;
            r_gnt_valid <= w_nxt_valid;
            r_gnt       <= w_nxt_gnt;
            r_hold_cnt  <= w_nxt_hold;
            r_timeout   <= w_nxt_timeout;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_idx     = r_gnt_idx;
    assign gnt_valid   = r_gnt_valid;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
module tb_rr_decode_arbiter;
    import rr_decode_arbiter_pkg::*;

    localparam int N        = 8;
    localparam int MAX_HOLD = 16;
    localparam int IW       = 3;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          timeout;
    arb_state_t    dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_decode_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .timeout     (timeout),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec;
    int n_bad;
    logic [IW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1 time unit after the edge,
    // and new inputs applied here take effect at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int idx);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
        check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, "_gnt"}, 32'(gnt), 32'(oh));
    endtask

    task automatic check_idle(input string tag, input logic exp_to);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    int cnt;
    logic [IW-1:0] e;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;

        // ---- reset / idle ----
        step();
        step();
        check_idle("rst", 1'b0);
        check("rst_idx", 32'(gnt_idx), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check({gnt_valid, timeout, gnt} == '0 ? "idle_quiet" : "idle_quiet",
                  32'({gnt_valid, timeout, gnt}), 32'd0);
        end

        // ---- single requester idx 2, done on 3rd grant cycle ----
        req = 8'b0000_0100;
        step();
        check_grant("single_c1", 2);
        check("single_state", 32'(dbg_state), 32'(ST_GRANT));
        step();
        check_grant("single_c2", 2);
        step();
        check_grant("single_c3", 2);
        done = 1'b1;
        step();
        done = 1'b0;
        check_idle("single_rel", 1'b0);
        check("single_rel_idx", 32'(gnt_idx), 32'd2);
        step();
        check_grant("single_regrant", 2);
        req = '0;
        step();
        check_idle("single_withdraw", 1'b0);

        // ---- rotation from ptr 0 ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(IW'(i));
        exp_q.push_back(IW'(0));
        req = 8'hFF;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            check_grant("rot", int'(e));
            done = 1'b1;
            step();
            done = 1'b0;
            check_idle("rot_bubble", 1'b0);
        end
        req = '0;
        step();

        // ---- timeout: only requester 7, no done ----
        req = 8'b1000_0000;
        step();
        check_grant("to_first", 7);
        cnt = 0;
        while (gnt_valid && cnt < 40) begin
            cnt++;
            if (timeout) check("to_early_pulse", 32'(timeout), 32'd0);
            step();
        end
        check("to_hold_len", 32'(cnt), 32'(MAX_HOLD));
        check_idle("to_rel", 1'b1);
        step();
        check_grant("to_regrant", 7);
        check("to_pulse_gone", 32'(timeout), 32'd0);
        req = '0;
        step();
        check_idle("to_withdraw", 1'b0);

        // ---- withdraw + done at the hold limit ----
        req = 8'b0000_1000;
        step();
        check_grant("wd_first", 3);
        req = 8'b0010_1010;
        for (int i = 1; i < MAX_HOLD; i++) begin
            step();
        end
        check_grant("wd_last_cycle", 3);
        done = 1'b1;
        req  = 8'b0010_0010;
        step();
        done = 1'b0;
        check_idle("wd_rel", 1'b0);
        step();
        check_grant("wd_next", 5);

        // ---- reset mid-grant ----
        done = 1'b1;
        req  = 8'b0100_0000;
        step();
        done = 1'b0;
        step();
        check_grant("mid_owner", 6);
        rst  = 1'b1;
        done = 1'b1;
        req  = 8'b0100_0001;
        step();
        rst  = 1'b0;
        done = 1'b0;
        check_idle("mid_rst", 1'b0);
        check("mid_rst_idx", 32'(gnt_idx), 32'd0);
        step();
        check_grant("mid_after", 0);

        // ---- done while idle is ignored ----
        req = '0;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        check_idle("idle_done", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
